// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the parking gate controller: state encoding,
// default bay count and display width.
package parking_pkg;

  localparam int NUM_SPACES_DEF = 3;
  localparam int FREE_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_PASS = 2'd1,
    ST_REJECT    = 2'd2
  } gate_state_e;

  // Seconds counter width: must hold the larger of the two hold times without wrapping.
  function automatic int sec_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor, lamp and gate signals between the lot hardware and the controller.
interface parking_gate_ctrl_if
  import parking_pkg::*;
#(
  parameter int NUM_SPACES = NUM_SPACES_DEF
) ();

  logic                  tick;
  logic [NUM_SPACES-1:0] occupied;
  logic                  car_arrive;
  logic                  car_passed;
  logic                  gate_open;
  logic                  green;
  logic                  full;
  logic                  admit;
  logic                  timeout;
  logic [FREE_W-1:0]     free_cnt;

  modport master (
    output tick, occupied, car_arrive, car_passed,
    input  gate_open, green, full, admit, timeout, free_cnt
  );

  modport slave (
    input  tick, occupied, car_arrive, car_passed,
    output gate_open, green, full, admit, timeout, free_cnt
  );

endinterface

// File: rtl/parking_gate_ctrl_bay_counter.sv
// Free-bay calculation: bay count minus the number of occupied bays.
// Purely combinational so the display path can reuse it on any registered vector.
module bay_counter
  import parking_pkg::*;
#(
  parameter int NUM_SPACES = NUM_SPACES_DEF
) (
  input  logic [NUM_SPACES-1:0] i_occupied,
  output logic [FREE_W-1:0]     o_free
);

  localparam int POP_W = $clog2(NUM_SPACES + 1);

  logic [POP_W-1:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_SPACES; i++) begin
      w_pop = w_pop + POP_W'(i_occupied[i]);
    end
  end

  assign o_free = FREE_W'(POP_W'(NUM_SPACES) - w_pop);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry barrier controller: admits a car when a bay is free, holds the gate
// until the car passes or OPEN_SEC elapses, and shows "full" on rejection.
//   state        | meaning
//   ST_IDLE      | waiting for an arrival; green when a bay is available
//   ST_WAIT_PASS | gate raised, one bay reserved, waiting for the car to pass
//   ST_REJECT    | lot was full at arrival; full lamp held for REJECT_SEC
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SPACES = NUM_SPACES_DEF,
  parameter int OPEN_SEC   = 5,
  parameter int REJECT_SEC = 3
) (
  input logic                clk,
  input logic                rst_n,
  parking_gate_ctrl_if.slave gate_bus
);

  localparam int               CNT_W       = sec_cnt_width(OPEN_SEC, REJECT_SEC);
  localparam logic [CNT_W-1:0] OPEN_LAST   = CNT_W'(OPEN_SEC - 1);
  localparam logic [CNT_W-1:0] REJECT_LAST = CNT_W'(REJECT_SEC - 1);

  gate_state_e           r_state;
  gate_state_e           w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_SPACES-1:0] r_occ_q;
  logic                  r_arr_d1;
  logic                  r_arr_d2;
  logic                  r_pas_d1;
  logic                  r_pas_d2;
  logic [FREE_W-1:0]     r_free_cnt;
  logic [FREE_W-1:0]     w_free;
  logic                  w_arrive_edge;
  logic                  w_passed_edge;
  logic                  w_reserved;
  logic                  w_admit;
  logic                  w_timeout;

  // Occupancy resets to all-taken so the lamps show "full" until real sensor data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ_q  <= '1;
      r_arr_d1 <= 1'b0;
      r_arr_d2 <= 1'b0;
      r_pas_d1 <= 1'b0;
      r_pas_d2 <= 1'b0;
    end else begin
      r_occ_q  <= gate_bus.occupied;
      r_arr_d1 <= gate_bus.car_arrive;
      r_arr_d2 <= r_arr_d1;
      r_pas_d1 <= gate_bus.car_passed;
      r_pas_d2 <= r_pas_d1;
    end
  end

  assign w_arrive_edge = r_arr_d1 & ~r_arr_d2;
  assign w_passed_edge = r_pas_d1 & ~r_pas_d2;

  bay_counter #(
    .NUM_SPACES (NUM_SPACES)
  ) u_bay_counter (
    .i_occupied (r_occ_q),
    .o_free     (w_free)
  );

  assign w_reserved = (r_state == ST_WAIT_PASS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_cnt <= '0;
    end else if (w_reserved) begin
      r_free_cnt <= (w_free == '0) ? '0 : w_free - FREE_W'(1);
    end else begin
      r_free_cnt <= w_free;
    end
  end

  // Cleared throughout IDLE so every WAIT_PASS/REJECT visit starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (gate_bus.tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_admit     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arrive_edge) begin
          if (r_free_cnt != '0) begin
            w_state_nxt = ST_WAIT_PASS;
            w_admit     = 1'b1;
          end else begin
            w_state_nxt = ST_REJECT;
          end
        end
      end
      ST_WAIT_PASS: begin
        // A pass on the terminal tick wins over the timeout.
        if (w_passed_edge) begin
          w_state_nxt = ST_IDLE;
        end else if (gate_bus.tick && (r_cnt == OPEN_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_REJECT: begin
        if (gate_bus.tick && (r_cnt == REJECT_LAST)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign gate_bus.gate_open = (r_state == ST_WAIT_PASS);
  assign gate_bus.admit     = w_admit;
  assign gate_bus.timeout   = w_timeout;
  assign gate_bus.green     = (r_state == ST_IDLE) && (r_free_cnt != '0);
  assign gate_bus.full      = (w_free == '0) || (r_state == ST_REJECT);
  assign gate_bus.free_cnt  = r_free_cnt;

endmodule
